// File: rtl/counter_seq_ctrl_pkg.sv
// Shared types and constants for the two-requester counter job sequencer.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        FIN  = 2'b11
    } state_t;

    localparam logic [1:0] MODE_ADD3 = 2'b00;
    localparam logic [1:0] MODE_ADD1 = 2'b01;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    localparam int REQ_N = 2;

endpackage

// File: rtl/counter_seq_ctrl_rr_arb2.sv
// Two-way round-robin grant; the last-served pointer moves only when a grant is taken.
// Combinational grant, registered pointer; grant is forced to zero while en is low.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    logic last;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last <= 1'b1;
        else if (|(req & grant))
            last <= grant[1];
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Arbitrates two counting jobs onto one shared load/step counter and returns the final count.
// Job latency N+3 cycles from accept to next possible accept; requests only accepted in IDLE.
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int CW = 4,
    parameter int SW = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REQ_N-1:0]     req_valid,
    output logic [REQ_N-1:0]     req_ready,
    input  logic [2*CW-1:0]      req_start,
    input  logic [3:0]           req_mode,
    input  logic [2*SW-1:0]      req_steps,
    output logic                 ctr_load,
    output logic                 ctr_count_en,
    output logic [1:0]           ctr_c,
    output logic [CW-1:0]        ctr_data,
    input  logic [CW-1:0]        ctr_count,
    output logic                 busy,
    output logic [REQ_N-1:0]     done,
    output logic [CW-1:0]        result
);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   job_start;
    logic [1:0]      job_mode;
    logic [SW-1:0]   job_steps;
    logic [SW-1:0]   remaining;
    logic            job_owner;
    logic [1:0]      grant;
    logic            accept;
    logic            sel;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .en    (state == IDLE),
        .grant (grant)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign sel       = grant[1];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOAD;
            LOAD:    state_nxt = (job_steps == '0) ? FIN : RUN;
            RUN:     if (remaining == SW'(1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Job fields are captured only on the accept edge, so later req_* changes cannot disturb a running job.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            job_start <= '0;
            job_mode  <= '0;
            job_steps <= '0;
            remaining <= '0;
            job_owner <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept) begin
                job_start <= sel ? req_start[2*CW-1:CW] : req_start[CW-1:0];
                job_mode  <= sel ? req_mode[3:2]        : req_mode[1:0];
                job_steps <= sel ? req_steps[2*SW-1:SW] : req_steps[SW-1:0];
                job_owner <= sel;
            end
            if (state == LOAD)
                remaining <= job_steps;
            else if (state == RUN)
                remaining <= remaining - SW'(1);
        end
    end

    always_comb begin
        ctr_load     = 1'b0;
        ctr_count_en = 1'b0;
        ctr_c        = 2'b00;
        ctr_data     = '0;
        busy         = (state != IDLE);
        done         = '0;
        result       = '0;
        case (state)
            LOAD: begin
                ctr_load = 1'b1;
                ctr_data = job_start;
            end
            RUN: begin
                ctr_count_en = 1'b1;
                ctr_c        = job_mode;
            end
            FIN: begin
                done[job_owner] = 1'b1;
                result          = ctr_count;
            end
            default: ;
        endcase
    end

endmodule
